// File: rtl/mu0_datapath.sv
// MU0 register/ALU datapath.
// Holds PC, IR and ACC, computes the ALU result, drives the memory address
// and write-data bus, and returns opcode/acc_15/accz to the control sequencer.
// Also counts retired instructions (IR loads) for debug.
//
// Ports:
//   clk, rst_n     clock; synchronous active-low reset
//   a_sel          address mux: 1 = IR operand address, 0 = PC
//   b_sel          ALU B mux: 1 = mem_rdata, 0 = zero-extended mem_addr
//   pc_ce          load PC from alu_y[AW-1:0]
//   ir_ce          load IR from mem_rdata (also bumps icount)
//   acc_ce         load ACC from alu_y
//   acc_oe         drive ACC onto mem_wdata
//   alufs          ALU function select
//   mem_rdata      memory read data
//   mem_addr       memory address (combinational)
//   mem_wdata      ACC when acc_oe, else 0 (combinational)
//   mem_wdata_oe   equals acc_oe
//   opcode         IR[DW-1:DW-4]
//   acc_15         ACC sign bit
//   accz           ACC == 0
//   icount         IR loads since reset, wrapping
module mu0_datapath #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 12,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_sel,
  input  logic          b_sel,
  input  logic          pc_ce,
  input  logic          ir_ce,
  input  logic          acc_ce,
  input  logic          acc_oe,
  input  logic [2:0]    alufs,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wdata_oe,
  output logic [3:0]    opcode,
  output logic          acc_15,
  output logic          accz,
  output logic [CW-1:0] icount
);

  localparam int unsigned OPW = 4;
  localparam int unsigned PADW = DW - AW;

  localparam logic [2:0] FN_A     = 3'd0;
  localparam logic [2:0] FN_ADD   = 3'd1;
  localparam logic [2:0] FN_SUB   = 3'd2;
  localparam logic [2:0] FN_B     = 3'd3;
  localparam logic [2:0] FN_B_INC = 3'd4;

  logic [AW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] acc;
  logic [CW-1:0] icnt;

  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_y;

  // Address mux: operand address from IR or the program counter.
  always_comb begin
    mem_addr = pc;
    if (a_sel) begin
      mem_addr = ir[AW-1:0];
    end
  end

  // ALU B operand: memory data or the zero-extended address.
  always_comb begin
    alu_b = {{PADW{1'b0}}, mem_addr};
    if (b_sel) begin
      alu_b = mem_rdata;
    end
  end

  // ALU; unused encodings produce zero. Results wrap modulo 2^DW.
  always_comb begin
    alu_y = '0;
    unique case (alufs)
      FN_A:     alu_y = acc;
      FN_ADD:   alu_y = DW'(acc + alu_b);
      FN_SUB:   alu_y = DW'(acc - alu_b);
      FN_B:     alu_y = alu_b;
      FN_B_INC: alu_y = DW'(alu_b + DW'(1));
      default:  alu_y = '0;
    endcase
  end

  // Architectural registers; every load samples pre-edge values only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc   <= '0;
      ir   <= '0;
      acc  <= '0;
      icnt <= '0;
    end else begin
      if (pc_ce) begin
        pc <= alu_y[AW-1:0];
      end
      if (ir_ce) begin
        ir   <= mem_rdata;
        icnt <= CW'(icnt + CW'(1));
      end
      if (acc_ce) begin
        acc <= alu_y;
      end
    end
  end

  // Write bus is gated to zero when ACC is not being stored.
  always_comb begin
    mem_wdata = '0;
    if (acc_oe) begin
      mem_wdata = acc;
    end
  end

  assign mem_wdata_oe = acc_oe;
  assign opcode       = ir[DW-1 -: OPW];
  assign acc_15       = acc[DW-1];
  assign accz         = (acc == '0);
  assign icount       = icnt;

endmodule

// File: doc/mu0_datapath.md
Name: mu0_datapath

Overview:
- Register/ALU datapath of the MU0 processor: holds PC, IR and ACC, computes ALU results and drives the memory address and write-data bus.
- Sits directly downstream of the MU0 control sequencer. It consumes a_sel, b_sel, pc_ce, ir_ce, acc_ce, acc_oe and alufs.
- It returns opcode, acc_15 and accz to the sequencer, closing the fetch/execute loop.
- Also provides a retired-instruction counter for debug.

Parameters:
- DW, 16, data/instruction word width.
- AW, 12, address width. IR[AW-1:0] is the operand address; IR[DW-1:DW-4] is the opcode.
- CW, 16, width of the instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a_sel  in  1  address mux: 1 = IR[AW-1:0], 0 = PC.
- b_sel  in  1  ALU B mux: 1 = mem_rdata, 0 = zero-extended address-mux output.
- pc_ce  in  1  load PC from alu_y[AW-1:0].
- ir_ce  in  1  load IR from mem_rdata.
- acc_ce  in  1  load ACC from alu_y.
- acc_oe  in  1  enable ACC onto write bus.
- alufs  in  3  ALU function select.
- mem_rdata  in  DW  memory read data.
- mem_addr  out  AW  memory address (address-mux output, combinational).
- mem_wdata  out  DW  write data: ACC when acc_oe=1, else 0.
- mem_wdata_oe  out  1  equals acc_oe.
- opcode  out  4  IR[DW-1:DW-4].
- acc_15  out  1  ACC[DW-1].
- accz  out  1  1 when ACC == 0.
- icount  out  CW  number of completed IR loads since reset.

Behaviour:
- Reset (rst_n=0 at posedge):
  - PC, IR, ACC and icount all clear to 0.
  - Reset dominates every enable.
  - Consequently opcode=0, acc_15=0, accz=1 and mem_addr=0 (when a_sel=0) in the cycle after reset.
- Reset mid-operation: the same clear applies. No partial load of any register survives.
- ALU: A = ACC; B = b_sel ? mem_rdata : {0, mem_addr}. Functions by alufs:
  - 0: y = A
  - 1: y = A + B, mod 2^DW
  - 2: y = A - B, mod 2^DW, two's complement
  - 3: y = B
  - 4: y = B + 1, mod 2^DW
  - 5, 6, 7: y = 0
  - Non-0/1 alufs bits (X from the sequencer): y is don't-care, but must not corrupt any register whose ce=0.
- Register loads at posedge, when rst_n=1:
  - PC <= alu_y[AW-1:0] if pc_ce.
  - IR <= mem_rdata if ir_ce.
  - ACC <= alu_y if acc_ce.
  - icount <= icount+1 if ir_ce. Wraps from 2^CW-1 to 0.
- Simultaneous enables:
  - pc_ce, ir_ce and acc_ce may all be 1 in one cycle. Each register uses pre-edge values of the others (single-cycle read-before-write).
  - Example: ir_ce=1 with pc_ce=1 and a_sel=1 (JMP) fetches the instruction at the IR address and sets PC to IR address+1 in the same edge.
- PC wrap: PC = 2^AW-1 with alufs=4, b_sel=0, a_sel=0, pc_ce=1 gives PC=0.
- Status outputs:
  - opcode, acc_15 and accz are combinational from the registers. They are valid one cycle after the load edge, with zero additional latency.
  - mem_addr, mem_wdata and mem_wdata_oe are combinational from their inputs and registers. There is no internal tri-state.
- All enables at 0: every register holds its value.

Test Plan:
- Reset: drive random enables with rst_n=0 for 2 cycles -> PC=0, IR=0, ACC=0, icount=0, accz=1, opcode=0.
- Fetch: PC=0x005, mem_rdata=0x2ABC, a_sel=0, b_sel=0, alufs=4, pc_ce=1, ir_ce=1 -> PC=0x006, IR=0x2ABC, opcode=2, icount=1.
- ADD/SUB wrap:
  - ACC=0xFFFF, b_sel=1, mem_rdata=0x0001, alufs=1, acc_ce=1 -> ACC=0x0000, accz=1.
  - Then alufs=2 with mem_rdata=0x0001 -> ACC=0xFFFF, acc_15=1.
- JMP: IR=0x4123, a_sel=1, b_sel=0, alufs=4, pc_ce=1, ir_ce=1 -> mem_addr=0x123 pre-edge, PC=0x124, IR=mem_rdata.
- Store: ACC=0x1234, a_sel=1, IR=0x1077, acc_oe=1, all ce=0 -> mem_addr=0x077, mem_wdata=0x1234, mem_wdata_oe=1; registers unchanged.
- Wraps:
  - PC=0xFFF with an increment step -> PC=0x000.
  - icount preloaded via 2^CW ir_ce pulses -> icount=0.
